// File: rtl/mrv1_wb_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mrv1_wb_arb: two-source (ALU/LSU) writeback arbiter with busy scoreboard |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mrv1_wb_arb #(
   parameter int DATA_WIDTH_P    = 32,
   parameter int NUM_TW_P        = 8,
   parameter int rf_addr_width_p = 5
) (
   input  logic                            clk_i,
   input  logic                            rst_i,

   input  logic                            alu_valid_i,
   output logic                            alu_ready_o,
   input  logic [$clog2(NUM_TW_P)-1:0]     alu_tid_i,
   input  logic                            alu_rd_w_en_i,
   input  logic [rf_addr_width_p-1:0]      alu_rd_addr_i,
   input  logic [DATA_WIDTH_P-1:0]         alu_rd_data_i,

   input  logic                            lsu_valid_i,
   output logic                            lsu_ready_o,
   input  logic [$clog2(NUM_TW_P)-1:0]     lsu_tid_i,
   input  logic                            lsu_rd_w_en_i,
   input  logic [rf_addr_width_p-1:0]      lsu_rd_addr_i,
   input  logic [DATA_WIDTH_P-1:0]         lsu_rd_data_i,

   output logic [$clog2(NUM_TW_P)-1:0]     rd_tid_o,
   output logic                            rd_w_en_o,
   output logic [rf_addr_width_p-1:0]      rd_addr_o,
   output logic [DATA_WIDTH_P-1:0]         rd_data_o,

   input  logic                            sb_set_i,
   input  logic [$clog2(NUM_TW_P)-1:0]     sb_set_tid_i,
   input  logic [rf_addr_width_p-1:0]      sb_set_addr_i,

   input  logic [$clog2(NUM_TW_P)-1:0]     sb_q_tid_i,
   input  logic [rf_addr_width_p-1:0]      sb_q_rs0_i,
   input  logic [rf_addr_width_p-1:0]      sb_q_rs1_i,
   input  logic [rf_addr_width_p-1:0]      sb_q_rd_i,
   output logic                            sb_hazard_o
);

   localparam int tid_width_lp = $clog2(NUM_TW_P);
   localparam int num_regs_lp  = 1 << rf_addr_width_p;

   // 1 = LSU has priority in the next two-way contention
   logic lsu_pri;

   logic                       alu_fire;
   logic                       lsu_fire;
   logic                       fire;
   logic [tid_width_lp-1:0]    sel_tid;
   logic                       sel_w_en;
   logic [rf_addr_width_p-1:0] sel_addr;
   logic [DATA_WIDTH_P-1:0]    sel_data;
   logic                       clr_en;

   logic [num_regs_lp-1:0]     busy [NUM_TW_P];

   assign alu_ready_o = !rst_i && alu_valid_i && (!lsu_valid_i || !lsu_pri);
   assign lsu_ready_o = !rst_i && lsu_valid_i && (!alu_valid_i ||  lsu_pri);

   assign alu_fire = alu_valid_i && alu_ready_o;
   assign lsu_fire = lsu_valid_i && lsu_ready_o;
   assign fire     = alu_fire || lsu_fire;

   always_comb begin
      sel_tid  = alu_tid_i;
      sel_w_en = alu_rd_w_en_i;
      sel_addr = alu_rd_addr_i;
      sel_data = alu_rd_data_i;
      if (lsu_fire) begin
         sel_tid  = lsu_tid_i;
         sel_w_en = lsu_rd_w_en_i;
         sel_addr = lsu_rd_addr_i;
         sel_data = lsu_rd_data_i;
      end
   end

   // x0 writes and stores are consumed without producing a register write
   assign clr_en = fire && sel_w_en && (sel_addr != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lsu_pri   <= 1'b0;
         rd_w_en_o <= 1'b0;
         rd_tid_o  <= '0;
         rd_addr_o <= '0;
         rd_data_o <= '0;
      end else begin
         if (alu_valid_i && lsu_valid_i) begin
            lsu_pri <= alu_fire;
         end
         rd_w_en_o <= clr_en;
         if (fire) begin
            rd_tid_o  <= sel_tid;
            rd_addr_o <= sel_addr;
            rd_data_o <= sel_data;
         end
      end
   end

   // Set is applied after clear so it wins on a same-entry collision
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int t = 0; t < NUM_TW_P; t++) begin
            busy[t] <= '0;
         end
      end else begin
         if (clr_en) begin
            busy[sel_tid][sel_addr] <= 1'b0;
         end
         if (sb_set_i && (sb_set_addr_i != '0)) begin
            busy[sb_set_tid_i][sb_set_addr_i] <= 1'b1;
         end
      end
   end

   assign sb_hazard_o = busy[sb_q_tid_i][sb_q_rs0_i]
                      | busy[sb_q_tid_i][sb_q_rs1_i]
                      | busy[sb_q_tid_i][sb_q_rd_i];

endmodule
`default_nettype wire

// File: tb/tb_mrv1_wb_arb.sv
`default_nettype none
// tb_mrv1_wb_arb: randomized + directed check of mrv1_wb_arb against a behavioural model.
module tb_mrv1_wb_arb;

   localparam int DW  = 32;
   localparam int NTW = 8;
   localparam int AW  = 5;
   localparam int TW  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, alu_ready, alu_w_en;
   logic [TW-1:0] alu_tid;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          lsu_valid, lsu_ready, lsu_w_en;
   logic [TW-1:0] lsu_tid;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_data;
   logic [TW-1:0] rd_tid;
   logic          rd_w_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          sb_set;
   logic [TW-1:0] sb_set_tid, q_tid;
   logic [AW-1:0] sb_set_addr, q_rs0, q_rs1, q_rd;
   logic          hazard;

   mrv1_wb_arb #(.DATA_WIDTH_P(DW), .NUM_TW_P(NTW), .rf_addr_width_p(AW)) dut (
      .clk_i(clk), .rst_i(rst),
      .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_tid_i(alu_tid),
      .alu_rd_w_en_i(alu_w_en), .alu_rd_addr_i(alu_addr), .alu_rd_data_i(alu_data),
      .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_tid_i(lsu_tid),
      .lsu_rd_w_en_i(lsu_w_en), .lsu_rd_addr_i(lsu_addr), .lsu_rd_data_i(lsu_data),
      .rd_tid_o(rd_tid), .rd_w_en_o(rd_w_en), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
      .sb_set_i(sb_set), .sb_set_tid_i(sb_set_tid), .sb_set_addr_i(sb_set_addr),
      .sb_q_tid_i(q_tid), .sb_q_rs0_i(q_rs0), .sb_q_rs1_i(q_rs1), .sb_q_rd_i(q_rd),
      .sb_hazard_o(hazard)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          busy_m [NTW][1 << AW];
   bit          last_win_lsu = 1'b1;   // "LSU won last contention" => ALU wins next
   bit          m_wen = 1'b0;
   bit          m_chk = 1'b0;
   logic [TW-1:0] m_tid = '0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;

   // 0 = nobody, 1 = ALU, 2 = LSU
   function automatic int grant(bit r, bit av, bit lv, bit lastlsu);
      if (r) return 0;
      if (av && lv) return lastlsu ? 1 : 2;
      if (av) return 1;
      if (lv) return 2;
      return 0;
   endfunction

   always @(posedge clk) begin : model
      int g;
      logic [TW-1:0] t;
      logic [AW-1:0] a;
      logic          w;
      g = grant(rst, alu_valid, lsu_valid, last_win_lsu);
      if (rst) begin
         for (int i = 0; i < NTW; i++)
            for (int j = 0; j < (1 << AW); j++) busy_m[i][j] <= 1'b0;
         last_win_lsu <= 1'b1;
         m_wen <= 1'b0; m_chk <= 1'b1;
         m_tid <= '0; m_addr <= '0; m_data <= '0;
      end else begin
         m_wen <= 1'b0; m_chk <= 1'b0;
         if (g != 0) begin
            t = (g == 1) ? alu_tid  : lsu_tid;
            a = (g == 1) ? alu_addr : lsu_addr;
            w = (g == 1) ? alu_w_en : lsu_w_en;
            if (w && a != 0) begin
               m_wen <= 1'b1; m_chk <= 1'b1;
               m_tid <= t; m_addr <= a;
               m_data <= (g == 1) ? alu_data : lsu_data;
               busy_m[t][a] <= 1'b0;
            end
         end
         if (alu_valid && lsu_valid) last_win_lsu <= (g == 2);
         if (sb_set && sb_set_addr != 0) busy_m[sb_set_tid][sb_set_addr] <= 1'b1;
      end
   end

   always @(negedge clk) begin : compare
      int g;
      bit hz;
      g  = grant(rst, alu_valid, lsu_valid, last_win_lsu);
      hz = busy_m[q_tid][q_rs0] | busy_m[q_tid][q_rs1] | busy_m[q_tid][q_rd];
      chk("alu_ready", alu_ready, (g == 1));
      chk("lsu_ready", lsu_ready, (g == 2));
      chk("hazard", hazard, hz);
      chk("rd_w_en", rd_w_en, m_wen);
      if (m_chk) begin
         chk("rd_tid", rd_tid, m_tid);
         chk("rd_addr", rd_addr, m_addr);
         chk("rd_data", rd_data, m_data);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; lsu_valid = 0; sb_set = 0;
   endtask

   task automatic drv_alu(input logic [TW-1:0] t, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic w);
      alu_valid = 1; alu_tid = t; alu_addr = a; alu_data = d; alu_w_en = w;
   endtask

   task automatic drv_lsu(input logic [TW-1:0] t, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic w);
      lsu_valid = 1; lsu_tid = t; lsu_addr = a; lsu_data = d; lsu_w_en = w;
   endtask

   task automatic query(input logic [TW-1:0] t, input logic [AW-1:0] r0,
                        input logic [AW-1:0] r1, input logic [AW-1:0] rd);
      q_tid = t; q_rs0 = r0; q_rs1 = r1; q_rd = rd;
   endtask

   task automatic do_reset();
      rst = 1; cyc(); cyc(); rst = 0;
   endtask

   initial begin
      rst = 1; idle();
      alu_tid = 0; alu_addr = 0; alu_data = 0; alu_w_en = 0;
      lsu_tid = 0; lsu_addr = 0; lsu_data = 0; lsu_w_en = 0;
      sb_set_tid = 0; sb_set_addr = 0;
      query(0, 0, 0, 0);
      cyc(); cyc();
      @(negedge clk);
      chk("reset_rd_w_en", rd_w_en, 0);
      chk("reset_rd_data", rd_data, 0);
      rst = 0;

      // single source
      cyc(); drv_alu(3, 5, 32'hDEADBEEF, 1);
      @(negedge clk); chk("single_alu_ready", alu_ready, 1);
      cyc(); idle();
      @(negedge clk);
      chk("single_w_en", rd_w_en, 1);
      chk("single_tid", rd_tid, 3);
      chk("single_addr", rd_addr, 5);
      chk("single_data", rd_data, 32'hDEADBEEF);

      // contention after reset: ALU, LSU, ALU, LSU
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            drv_alu(1, 3, 32'hA0 + k, 1);
            drv_lsu(2, 4, 32'hB0 + k, 1);
         end else idle();
         @(negedge clk);
         if (k < 4) chk("cont_alu_ready", alu_ready, (k % 2 == 0));
         if (k > 0) begin
            chk("cont_w_en", rd_w_en, 1);
            chk("cont_data", rd_data, ((k - 1) % 2 == 0) ? 32'hA0 + k - 1 : 32'hB0 + k - 1);
         end
         cyc();
      end

      // x0 and store cases
      sb_set = 1; sb_set_tid = 1; sb_set_addr = 6;
      cyc(); sb_set = 0; drv_alu(1, 0, 32'h1234, 1);
      cyc(); idle(); drv_lsu(1, 6, 32'h5678, 0);
      @(negedge clk); chk("x0_w_en", rd_w_en, 0);
      cyc(); idle(); query(1, 6, 0, 0);
      @(negedge clk);
      chk("store_w_en", rd_w_en, 0);
      chk("store_busy_kept", hazard, 1);

      // scoreboard lifecycle
      cyc(); sb_set = 1; sb_set_tid = 2; sb_set_addr = 7;
      cyc(); sb_set = 0; query(2, 7, 0, 0);
      @(negedge clk); chk("sb_hz_tid2", hazard, 1);
      cyc(); query(1, 7, 0, 0);
      @(negedge clk); chk("sb_hz_tid1", hazard, 0);
      cyc(); query(2, 7, 0, 0); drv_alu(2, 7, 32'h77, 1);
      @(negedge clk); chk("sb_no_bypass", hazard, 1);
      cyc(); idle();
      @(negedge clk); chk("sb_cleared", hazard, 0);

      // simultaneous set and clear
      cyc(); sb_set = 1; sb_set_tid = 4; sb_set_addr = 9;
      cyc(); drv_alu(4, 9, 32'h99, 1);
      cyc(); idle(); query(4, 0, 0, 9);
      @(negedge clk); chk("set_wins", hazard, 1);

      // reset mid-stream
      cyc(); drv_alu(0, 1, 32'h11, 1); drv_lsu(5, 2, 32'h22, 1);
      cyc(); rst = 1;
      @(negedge clk);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_lsu_ready", lsu_ready, 0);
      cyc();
      @(negedge clk);
      chk("rst_w_en", rd_w_en, 0);
      for (int t = 0; t < NTW; t++) begin
         query(t[TW-1:0], 9, 6, 7); #1;
         chk("rst_hazard", hazard, 0);
      end
      rst = 0;
      @(negedge clk); chk("rst_alu_first", alu_ready, 1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         rst       = ($urandom_range(0, 99) == 0);
         alu_valid = $urandom_range(0, 1);
         lsu_valid = $urandom_range(0, 1);
         alu_tid   = $urandom_range(0, NTW - 1); lsu_tid = $urandom_range(0, NTW - 1);
         alu_addr  = $urandom_range(0, 7);      lsu_addr = $urandom_range(0, 7);
         alu_w_en  = ($urandom_range(0, 3) != 0); lsu_w_en = ($urandom_range(0, 3) != 0);
         alu_data  = $urandom;                  lsu_data = $urandom;
         sb_set    = $urandom_range(0, 1);
         sb_set_tid  = $urandom_range(0, NTW - 1);
         sb_set_addr = $urandom_range(0, 7);
         query($urandom_range(0, NTW - 1), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7));
      end
      cyc(); rst = 0; idle();
      cyc(); cyc();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mrv1_wb_arb.md
MRV1_WB_ARB -- requirements
Module: mrv1_wb_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 32, meaning the result data width.
REQ-002 SHALL have parameter NUM_TW_P, default 8, meaning the number of hardware threads.
REQ-003 SHALL have parameter rf_addr_width_p, default 5, meaning the architectural register index width.
REQ-004 SHALL derive localparam tid_width_lp = $clog2(NUM_TW_P).
REQ-005 SHALL have port clk_i  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  meaning synchronous, active-high reset.
REQ-007 SHALL have ALU result ports alu_valid_i in 1, alu_ready_o out 1, alu_tid_i in tid_width_lp, alu_rd_w_en_i in 1, alu_rd_addr_i in rf_addr_width_p, alu_rd_data_i in DATA_WIDTH_P.
REQ-008 SHALL have LSU result ports lsu_valid_i, lsu_ready_o, lsu_tid_i, lsu_rd_w_en_i, lsu_rd_addr_i, lsu_rd_data_i with the same widths as REQ-007.
REQ-009 SHALL have register-file write outputs rd_tid_o out tid_width_lp, rd_w_en_o out 1, rd_addr_o out rf_addr_width_p, rd_data_o out DATA_WIDTH_P.
REQ-010 SHALL have scoreboard set ports sb_set_i in 1, sb_set_tid_i in tid_width_lp, sb_set_addr_i in rf_addr_width_p, driven by issue.
REQ-011 SHALL have hazard query ports sb_q_tid_i in tid_width_lp, sb_q_rs0_i, sb_q_rs1_i, sb_q_rd_i in rf_addr_width_p, and sb_hazard_o out 1.

Function
REQ-012 SHALL accept a source transfer on a cycle when its valid_i and ready_o are both 1.
REQ-013 SHALL assert at most one of alu_ready_o and lsu_ready_o per cycle; ready_o SHALL be 0 for a source whose valid_i is 0.
REQ-014 SHALL grant the only valid source immediately.
REQ-015 SHALL, when both sources are valid, grant the source not granted in the most recent two-way contention; the round-robin pointer SHALL update only on contention cycles.
REQ-016 SHALL register the granted result into rd_* outputs, giving rd_* one cycle after acceptance; sustained throughput SHALL be one result per cycle.
REQ-017 SHALL drive rd_w_en_o = 0 in any cycle where no transfer was accepted on the prior cycle.
REQ-018 SHALL drive rd_w_en_o = 0 for an accepted result with rd_w_en_i = 0 or rd_addr_i = 0, consuming it without a register write.
REQ-019 SHALL maintain a NUM_TW_P x 2^rf_addr_width_p busy-bit scoreboard.
REQ-020 SHALL set busy[sb_set_tid_i][sb_set_addr_i] on a cycle with sb_set_i = 1 and sb_set_addr_i != 0.
REQ-021 SHALL clear busy[tid][addr] on the acceptance cycle of a result with rd_w_en_i = 1 and addr != 0.
REQ-022 SHALL let set win when set and clear target the same entry in the same cycle.
REQ-023 SHALL never set busy bits for register 0; register 0 SHALL always read not-busy.
REQ-024 SHALL compute sb_hazard_o combinationally as busy[q_tid][rs0] OR busy[q_tid][rs1] OR busy[q_tid][rd], using registered scoreboard state without same-cycle clear bypass.
REQ-025 SHALL leave busy bits of threads other than the addressed ones unchanged.

Reset
REQ-026 SHALL, with rst_i = 1 at a clock edge, clear all busy bits, drive rd_w_en_o = 0, rd_tid_o = 0, rd_addr_o = 0, rd_data_o = 0, and set the round-robin pointer so the ALU wins the first contention.
REQ-027 SHALL force alu_ready_o = 0 and lsu_ready_o = 0 while rst_i = 1, so no transfer is accepted during reset.
REQ-028 SHALL discard any result accepted in the cycle before reset assertion; rd_w_en_o SHALL be 0 after the reset edge.

Verification
REQ-029 SHALL cover single source: ALU valid, tid 3, addr 5, data 0xDEADBEEF, w_en 1 -> alu_ready_o = 1 the same cycle; next cycle rd_w_en_o = 1, rd_tid_o = 3, rd_addr_o = 5, rd_data_o = 0xDEADBEEF.
REQ-030 SHALL cover contention: both sources valid for 4 cycles after reset -> grants ALU, LSU, ALU, LSU with 4 consecutive rd_w_en_o pulses.
REQ-031 SHALL cover x0 and store cases: accepted result with addr 0 or w_en 0 -> rd_w_en_o = 0 and scoreboard unchanged.
REQ-032 SHALL cover scoreboard lifecycle: set tid 2, reg 7 -> query tid 2, rs0 7 gives hazard 1; query tid 1, rs0 7 gives 0; after ALU writeback of tid 2, reg 7, hazard = 0 the following cycle.
REQ-033 SHALL cover simultaneous set and clear of tid 4, reg 9 -> busy remains 1 and hazard = 1.
REQ-034 SHALL cover reset mid-stream: rst_i asserted while both sources are valid -> both ready_o = 0, rd_w_en_o = 0, all hazards 0, and ALU wins the first contention after release.
